// File: rtl/correlator_defs.sv
// Shared command-path constants and types for the correlator host link.
package correlator_defs;

    localparam logic [7:0]  SYNC_BYTE       = 8'hA5;
    localparam logic [7:0]  OP_SET_INTEG    = 8'h01;
    localparam logic [7:0]  OP_SET_DELAY    = 8'h02;
    localparam logic [7:0]  OP_START        = 8'h03;
    localparam logic [7:0]  OP_STOP         = 8'h04;
    localparam logic [15:0] INTEG_LEN_RESET = 16'd1000;
    localparam int          FRAME_LEN       = 5;

    // Byte receiver states
    //  state    | meaning
    //  RX_IDLE  | line idle, waiting for a high-to-low transition
    //  RX_START | timing to the middle of the start bit to reject glitches
    //  RX_DATA  | sampling 8 data bits, LSB first, one bit period apart
    //  RX_STOP  | sampling the stop bit; high = good byte, low = framing error
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Frame parser states
    //  state  | meaning
    //  P_SYNC | hunting for SYNC_BYTE; anything else is dropped silently
    //  P_BODY | collecting OP, D1, D0 and CHK (byte index 1..FRAME_LEN-1)
    typedef enum logic {
        P_SYNC,
        P_BODY
    } parse_state_t;

    // Frame check byte: XOR of the three payload bytes.
    function automatic logic [7:0] frame_chk(input logic [7:0] op,
                                             input logic [7:0] d1,
                                             input logic [7:0] d0);
        return op ^ d1 ^ d0;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, mid-bit sampling, byte FSM.
// Reusable by any host-side receiver; it knows nothing about command frames.
module uart_rx_byte
    import correlator_defs::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clki,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             byte_valid_q;
    logic [7:0]       byte_data_q;
    logic             frame_err_q;

    // Bring the asynchronous line into the clki domain; idle level is high.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Byte FSM with down-counter bit timing. A new start is only armed by a
    // falling edge, so after a low stop bit the line must return high first.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            rx_prev_q    <= 1'b1;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'h00;
            frame_err_q  <= 1'b0;
        end else begin
            rx_prev_q    <= rx_sync_q;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RX_START;
                        cnt_q   <= HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (cnt_q == '0) begin
                        if (rx_sync_q) begin
                            state_q <= RX_IDLE;
                        end else begin
                            state_q   <= RX_DATA;
                            cnt_q     <= FULL_LOAD;
                            bit_idx_q <= 3'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == '0) begin
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        cnt_q   <= FULL_LOAD;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == '0) begin
                        if (rx_sync_q) begin
                            byte_valid_q <= 1'b1;
                            byte_data_q  <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Receive end of the correlator host UART link: frame parser, inter-byte
// timeout and the correlator control registers it drives.
module uart_cmd_rx
    import correlator_defs::*;
#(
    parameter int CLK_FREQUENCY = 50000000,
    parameter int BAUD_RATE     = 230400,
    parameter int NUM_INPUTS    = 14,
    parameter int MAX_DELAY     = 1,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic        clki,
    input  logic        rst_n,
    input  logic        RX,
    output logic [15:0] integ_len,
    output logic        run,
    output logic        delay_wr,
    output logic [3:0]  delay_idx,
    output logic [7:0]  delay_val,
    output logic        cmd_ok,
    output logic        cmd_err
);

    localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
    localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W         = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TO_CYCLES - 1);
    localparam logic [2:0]      LAST_IDX = 3'(FRAME_LEN - 1);
    localparam logic [7:0]      NUM_IN_B = 8'(NUM_INPUTS);
    localparam logic [7:0]      MAX_DL_B = 8'(MAX_DELAY);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clki         (clki),
        .rst_n        (rst_n),
        .rx_i         (RX),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .frame_err_o  (frame_err)
    );

    parse_state_t    pstate_q;
    logic [2:0]      byte_cnt_q;
    logic [7:0]      op_q;
    logic [7:0]      d1_q;
    logic [7:0]      d0_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout_hit;
    logic [15:0]     integ_len_q;
    logic            run_q;
    logic            delay_wr_q;
    logic [3:0]      delay_idx_q;
    logic [7:0]      delay_val_q;
    logic            cmd_ok_q;
    logic            cmd_err_q;

    // Inter-byte idle timer: reloads on every byte and while hunting for sync.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= TO_LOAD;
        end else if (byte_valid || (pstate_q == P_SYNC)) begin
            to_cnt_q <= TO_LOAD;
        end else if (to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - 1'b1;
        end
    end

    assign timeout_hit = (pstate_q != P_SYNC) && (to_cnt_q == '0);

    // Frame parser and control registers; a frame only takes effect once its
    // check byte is good, so rejected frames leave every register untouched.
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q    <= P_SYNC;
            byte_cnt_q  <= 3'd0;
            op_q        <= 8'h00;
            d1_q        <= 8'h00;
            d0_q        <= 8'h00;
            integ_len_q <= INTEG_LEN_RESET;
            run_q       <= 1'b0;
            delay_wr_q  <= 1'b0;
            delay_idx_q <= 4'd0;
            delay_val_q <= 8'h00;
            cmd_ok_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            delay_wr_q <= 1'b0;
            cmd_ok_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            if (frame_err) begin
                cmd_err_q <= 1'b1;
                pstate_q  <= P_SYNC;
            end else if (byte_valid) begin
                if (pstate_q == P_SYNC) begin
                    if (byte_data == SYNC_BYTE) begin
                        pstate_q   <= P_BODY;
                        byte_cnt_q <= 3'd1;
                    end
                end else begin
                    case (byte_cnt_q)
                        3'd1:    op_q <= byte_data;
                        3'd2:    d1_q <= byte_data;
                        3'd3:    d0_q <= byte_data;
                        default: ;
                    endcase
                    if (byte_cnt_q == LAST_IDX) begin
                        pstate_q <= P_SYNC;
                        if (byte_data != frame_chk(op_q, d1_q, d0_q)) begin
                            cmd_err_q <= 1'b1;
                        end else begin
                            case (op_q)
                                OP_SET_INTEG: begin
                                    if ({d1_q, d0_q} == 16'd0) begin
                                        cmd_err_q <= 1'b1;
                                    end else begin
                                        integ_len_q <= {d1_q, d0_q};
                                        cmd_ok_q    <= 1'b1;
                                    end
                                end
                                OP_SET_DELAY: begin
                                    if ((d1_q < NUM_IN_B) && (d0_q <= MAX_DL_B)) begin
                                        delay_idx_q <= d1_q[3:0];
                                        delay_val_q <= d0_q;
                                        delay_wr_q  <= 1'b1;
                                        cmd_ok_q    <= 1'b1;
                                    end else begin
                                        cmd_err_q <= 1'b1;
                                    end
                                end
                                OP_START: begin
                                    run_q    <= 1'b1;
                                    cmd_ok_q <= 1'b1;
                                end
                                OP_STOP: begin
                                    run_q    <= 1'b0;
                                    cmd_ok_q <= 1'b1;
                                end
                                default: cmd_err_q <= 1'b1;
                            endcase
                        end
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                    end
                end
            end else if (timeout_hit) begin
                pstate_q <= P_SYNC;
            end
        end
    end

    assign integ_len = integ_len_q;
    assign run       = run_q;
    assign delay_wr  = delay_wr_q;
    assign delay_idx = delay_idx_q;
    assign delay_val = delay_val_q;
    assign cmd_ok    = cmd_ok_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed frames plus randomized frames, each checked
// against a command-level model of what the host link should do.
module tb_uart_cmd_rx;

    // clki is chosen as 16x the line rate so every bit is 16 clocks.
    localparam int BAUD = 230400;
    localparam int CLKF = BAUD * 16;
    localparam int CPB  = CLKF / BAUD;

    logic        clki  = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX    = 1'b1;
    logic [15:0] integ_len;
    logic        run;
    logic        delay_wr;
    logic [3:0]  delay_idx;
    logic [7:0]  delay_val;
    logic        cmd_ok;
    logic        cmd_err;

    always #10 clki = ~clki;

    uart_cmd_rx #(
        .CLK_FREQUENCY (CLKF),
        .BAUD_RATE     (BAUD),
        .NUM_INPUTS    (14),
        .MAX_DELAY     (1),
        .TIMEOUT_BITS  (20)
    ) dut (
        .clki      (clki),
        .rst_n     (rst_n),
        .RX        (RX),
        .integ_len (integ_len),
        .run       (run),
        .delay_wr  (delay_wr),
        .delay_idx (delay_idx),
        .delay_val (delay_val),
        .cmd_ok    (cmd_ok),
        .cmd_err   (cmd_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // pulse counters, stepped only by the monitor
    int         n_ok = 0;
    int         n_err = 0;
    int         n_wr = 0;
    logic [3:0] last_idx = 4'd0;
    logic [7:0] last_val = 8'd0;

    always @(negedge clki) begin
        if (cmd_ok)  n_ok++;
        if (cmd_err) n_err++;
        if (delay_wr) begin
            n_wr++;
            last_idx = delay_idx;
            last_val = delay_val;
        end
    end

    // reference model of the control state
    logic [15:0] m_integ;
    logic        m_run;
    logic [3:0]  m_idx;
    logic [7:0]  m_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_integ = 16'd1000;
        m_run   = 1'b0;
        m_idx   = 4'd0;
        m_val   = 8'd0;
    endtask

    // Command rules: good check byte first, then opcode-specific legality.
    task automatic model_frame(input logic [7:0] op, input logic [7:0] d1,
                               input logic [7:0] d0, input logic [7:0] ck,
                               output int e_ok, output int e_err, output int e_wr);
        e_ok = 0; e_err = 0; e_wr = 0;
        if (ck !== (op ^ d1 ^ d0)) begin
            e_err = 1;
        end else if (op == 8'h01) begin
            if (d1 == 8'd0 && d0 == 8'd0) e_err = 1;
            else begin m_integ = {d1, d0}; e_ok = 1; end
        end else if (op == 8'h02) begin
            if (int'(d1) < 14 && int'(d0) <= 1) begin
                m_idx = d1[3:0]; m_val = d0; e_ok = 1; e_wr = 1;
            end else e_err = 1;
        end else if (op == 8'h03) begin
            m_run = 1'b1; e_ok = 1;
        end else if (op == 8'h04) begin
            m_run = 1'b0; e_ok = 1;
        end else begin
            e_err = 1;
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clki);
    endtask

    task automatic drive_bit(input logic v);
        RX = v;
        wait_clks(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        RX = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        RX = 1'b1;
        wait_clks(n * CPB);
    endtask

    task automatic check_state(input string tag, input int d_ok, input int d_err, input int d_wr,
                               input int e_ok, input int e_err, input int e_wr);
        check({tag, ".cmd_ok"},    32'(d_ok),  32'(e_ok));
        check({tag, ".cmd_err"},   32'(d_err), 32'(e_err));
        check({tag, ".delay_wr"},  32'(d_wr),  32'(e_wr));
        check({tag, ".integ_len"}, 32'(integ_len), 32'(m_integ));
        check({tag, ".run"},       32'(run), 32'(m_run));
        check({tag, ".delay_idx"}, 32'(delay_idx), 32'(m_idx));
        check({tag, ".delay_val"}, 32'(delay_val), 32'(m_val));
        if (e_wr == 1) begin
            check({tag, ".wr_idx"}, 32'(last_idx), 32'(m_idx));
            check({tag, ".wr_val"}, 32'(last_val), 32'(m_val));
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] op, input logic [7:0] d1,
                             input logic [7:0] d0, input logic [7:0] ck);
        int ok0, err0, wr0, e_ok, e_err, e_wr;
        ok0 = n_ok; err0 = n_err; wr0 = n_wr;
        send_byte(8'hA5, 1'b1);
        send_byte(op, 1'b1);
        send_byte(d1, 1'b1);
        send_byte(d0, 1'b1);
        send_byte(ck, 1'b1);
        idle_bits(2);
        model_frame(op, d1, d0, ck, e_ok, e_err, e_wr);
        check_state(tag, n_ok - ok0, n_err - err0, n_wr - wr0, e_ok, e_err, e_wr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".integ_len"}, 32'(integ_len), 32'd1000);
        check({tag, ".run"},       32'(run),       32'd0);
        check({tag, ".delay_wr"},  32'(delay_wr),  32'd0);
        check({tag, ".delay_idx"}, 32'(delay_idx), 32'd0);
        check({tag, ".delay_val"}, 32'(delay_val), 32'd0);
        check({tag, ".cmd_ok"},    32'(cmd_ok),    32'd0);
        check({tag, ".cmd_err"},   32'(cmd_err),   32'd0);
    endtask

    initial begin
        int ok0, err0, wr0;
        logic [7:0] op, d1, d0, ck;
        int sel;

        model_reset();
        wait_clks(5);
        check_reset_values("in_reset");
        rst_n = 1'b1;
        wait_clks(5);
        check_reset_values("after_reset");

        // integration length, delay writes, run control
        run_frame("integ_3e8",   8'h01, 8'h03, 8'hE8, 8'hEA);
        run_frame("delay_5_1",   8'h02, 8'h05, 8'h01, 8'h06);
        run_frame("delay_idx14", 8'h02, 8'h0E, 8'h01, 8'h0D);
        run_frame("delay_idx13", 8'h02, 8'h0D, 8'h01, 8'h0E);
        run_frame("delay_val2",  8'h02, 8'h03, 8'h02, 8'h03);
        run_frame("start",       8'h03, 8'h00, 8'h00, 8'h03);
        run_frame("start_again", 8'h03, 8'h00, 8'h00, 8'h03);
        run_frame("stop",        8'h04, 8'h00, 8'h00, 8'h04);
        run_frame("stop_again",  8'h04, 8'h00, 8'h00, 8'h04);

        // rejected frames, then recovery
        run_frame("bad_chk",     8'h01, 8'h00, 8'h10, 8'h00);
        run_frame("after_bad",   8'h01, 8'h00, 8'h10, 8'h11);
        run_frame("integ_zero",  8'h01, 8'h00, 8'h00, 8'h01);
        run_frame("bad_opcode",  8'h07, 8'h00, 8'h00, 8'h07);
        run_frame("a5_payload",  8'h01, 8'hA5, 8'hA5, 8'h01);

        // low stop bit on the OP byte
        ok0 = n_ok; err0 = n_err; wr0 = n_wr;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b0);
        idle_bits(2);
        check_state("frame_err", n_ok - ok0, n_err - err0, n_wr - wr0, 0, 1, 0);
        run_frame("after_ferr", 8'h01, 8'h00, 8'h40, 8'h41);

        // short low glitch on an idle line
        ok0 = n_ok; err0 = n_err; wr0 = n_wr;
        RX = 1'b0;
        wait_clks(2);
        idle_bits(3);
        check_state("glitch", n_ok - ok0, n_err - err0, n_wr - wr0, 0, 0, 0);
        run_frame("after_glitch", 8'h03, 8'h12, 8'h34, 8'h25);

        // partial frame abandoned for longer than the timeout
        ok0 = n_ok; err0 = n_err; wr0 = n_wr;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        idle_bits(25);
        check_state("partial", n_ok - ok0, n_err - err0, n_wr - wr0, 0, 0, 0);
        run_frame("after_timeout", 8'h01, 8'h12, 8'h34, 8'h27);

        // randomized frames
        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(0, 9));
            d1 = 8'($urandom_range(0, 255));
            d0 = 8'($urandom_range(0, 255));
            if (sel <= 2) op = 8'h01;
            else if (sel <= 5) begin
                op = 8'h02;
                d1 = 8'($urandom_range(0, 16));
                d0 = 8'($urandom_range(0, 2));
            end
            else if (sel == 6) op = 8'h03;
            else if (sel == 7) op = 8'h04;
            else if (sel == 8) op = 8'($urandom_range(0, 255));
            else begin
                op = 8'h01; d1 = 8'h00; d0 = 8'h00;
            end
            ck = op ^ d1 ^ d0;
            if ($urandom_range(0, 7) == 0) ck = ck ^ (8'h01 << $urandom_range(0, 7));
            run_frame($sformatf("rand%0d", i), op, d1, d0, ck);
        end

        // reset in the middle of a byte
        run_frame("pre_rst_run",   8'h03, 8'h00, 8'h00, 8'h03);
        run_frame("pre_rst_integ", 8'h01, 8'h07, 8'h77, 8'h71);
        run_frame("pre_rst_delay", 8'h02, 8'h09, 8'h01, 8'h0A);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_byte_rst");
        model_reset();
        wait_clks(3);
        RX = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        ok0 = n_ok; err0 = n_err; wr0 = n_wr;
        idle_bits(2);
        check_state("post_rst", n_ok - ok0, n_err - err0, n_wr - wr0, 0, 0, 0);
        run_frame("post_rst_frame", 8'h01, 8'h00, 8'h64, 8'h65);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
